// File: rtl/vga_timing_pkg.sv
// Shared types and helpers for the VGA timing decoder: lock FSM states,
// default counter width and a saturating increment.
package vga_timing_pkg;

    localparam int unsigned RES_SIZE = 10;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_pulse_meter.sv
// Measures an active-low sync stream on a tick enable: period between falls,
// low-run width, position since the last fall, fall pulse and saturation.
module sync_pulse_meter
    import vga_timing_pkg::*;
#(
    parameter int unsigned Width = RES_SIZE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             sync_ni,
    output logic [Width-1:0] period_o,
    output logic [Width-1:0] width_o,
    output logic [Width-1:0] pos_o,
    output logic             fall_o,
    output logic             fall_det_o,
    output logic             sat_det_o
);

    localparam logic [Width-1:0] MaxVal = '1;
    localparam logic [Width-1:0] PreMax = {{(Width-1){1'b1}}, 1'b0};
    localparam logic [Width-1:0] One    = {{(Width-1){1'b0}}, 1'b1};

    function automatic logic [Width-1:0] inc(input logic [Width-1:0] v);
        return Width'(sat_inc(32'(v), 32'(MaxVal)));
    endfunction

    logic             prev_q, prev_d;
    logic [Width-1:0] pos_q, pos_d;
    logic [Width-1:0] low_q, low_d;
    logic [Width-1:0] period_q, period_d;
    logic [Width-1:0] width_q, width_d;
    logic             fall_q;
    logic             fall, rise;

    assign fall = tick_i && prev_q && !sync_ni;
    assign rise = tick_i && !prev_q && sync_ni;

    always_comb begin
        prev_d   = prev_q;
        pos_d    = pos_q;
        low_d    = low_q;
        period_d = period_q;
        width_d  = width_q;
        if (tick_i) begin
            prev_d = sync_ni;
            if (fall) begin
                pos_d    = '0;
                period_d = inc(pos_q);
                low_d    = One;
            end else begin
                pos_d = inc(pos_q);
                if (!sync_ni) begin
                    low_d = inc(low_q);
                end
            end
            // Low run is complete on the rise; latch the count before it restarts.
            if (rise) begin
                width_d = low_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q   <= 1'b1;
            pos_q    <= '0;
            low_q    <= '0;
            period_q <= '0;
            width_q  <= '0;
            fall_q   <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            pos_q    <= pos_d;
            low_q    <= low_d;
            period_q <= period_d;
            width_q  <= width_d;
            fall_q   <= fall;
        end
    end

    assign period_o   = period_q;
    assign width_o    = width_q;
    assign pos_o      = pos_q;
    assign fall_o     = fall_q;
    assign fall_det_o = fall;
    assign sat_det_o  = tick_i && !fall && (pos_q == PreMax);

endmodule

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers x/y position from hsync/vsync,
// measures line/frame geometry and locks once it is stable for LockFrames frames.
module vga_timing_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned ResolutionSize = RES_SIZE,
    parameter int unsigned LockFrames     = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      PixelClock,
    input  logic                      hsync,
    input  logic                      vsync,
    output logic [ResolutionSize-1:0] xpos,
    output logic [ResolutionSize-1:0] ypos,
    output logic [ResolutionSize-1:0] LineLength,
    output logic [ResolutionSize-1:0] HSyncWidth,
    output logic [ResolutionSize-1:0] FrameLines,
    output logic [ResolutionSize-1:0] VSyncWidth,
    output logic                      LineEnd,
    output logic                      FrameEnd,
    output logic                      Locked,
    output logic                      TimingError
);

    localparam logic [ResolutionSize-1:0] MaxVal = '1;

    function automatic logic [ResolutionSize-1:0] inc(input logic [ResolutionSize-1:0] v);
        return ResolutionSize'(sat_inc(32'(v), 32'(MaxVal)));
    endfunction

    logic h_fall, h_sat, v_fall, v_sat;

    sync_pulse_meter #(.Width(ResolutionSize)) u_hsync_meter (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .tick_i     (PixelClock),
        .sync_ni    (hsync),
        .period_o   (LineLength),
        .width_o    (HSyncWidth),
        .pos_o      (xpos),
        .fall_o     (LineEnd),
        .fall_det_o (h_fall),
        .sat_det_o  (h_sat)
    );

    // Vertical meter ticks once per line, so a vsync fall shares the enable of an hsync fall.
    sync_pulse_meter #(.Width(ResolutionSize)) u_vsync_meter (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .tick_i     (h_fall),
        .sync_ni    (vsync),
        .period_o   (FrameLines),
        .width_o    (VSyncWidth),
        .pos_o      (ypos),
        .fall_o     (FrameEnd),
        .fall_det_o (v_fall),
        .sat_det_o  (v_sat)
    );

    state_e                    state_q, state_d;
    logic [2:0]                match_q, match_d;
    logic [ResolutionSize-1:0] stored_len_q, stored_len_d;
    logic [ResolutionSize-1:0] stored_lines_q, stored_lines_d;
    logic [ResolutionSize-1:0] ref_len_q, ref_len_d;
    logic                      first_q, first_d;
    logic                      cons_q, cons_d;
    logic                      terr_q, terr_d;

    logic [ResolutionSize-1:0] new_len, new_lines;
    logic                      frame_ok, pair_eq;

    assign new_len   = inc(xpos);
    assign new_lines = inc(ypos);
    assign frame_ok  = cons_q && (first_q || (new_len == ref_len_q));
    assign pair_eq   = (new_len == stored_len_q) && (new_lines == stored_lines_q);

    // The line closed by a vsync fall still belongs to the ending frame.
    always_comb begin
        ref_len_d = ref_len_q;
        first_d   = first_q;
        cons_d    = cons_q;
        if (h_fall) begin
            if (v_fall) begin
                first_d = 1'b1;
                cons_d  = 1'b1;
            end else if (first_q) begin
                ref_len_d = new_len;
                first_d   = 1'b0;
            end else if (new_len != ref_len_q) begin
                cons_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        match_d        = match_q;
        stored_len_d   = stored_len_q;
        stored_lines_d = stored_lines_q;
        terr_d         = 1'b0;
        if (h_sat || v_sat) begin
            terr_d  = 1'b1;
            state_d = ST_SEARCH;
            match_d = '0;
        end else begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (v_fall) begin
                        state_d = ST_MEASURE;
                        match_d = '0;
                    end
                end
                ST_MEASURE: begin
                    if (v_fall) begin
                        if (frame_ok && pair_eq) begin
                            match_d = match_q + 3'd1;
                        end else begin
                            stored_len_d   = new_len;
                            stored_lines_d = new_lines;
                            match_d        = {2'b00, frame_ok};
                        end
                        if (match_d == 3'(LockFrames)) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((h_fall && (new_len != stored_len_q)) ||
                        (v_fall && (new_lines != stored_lines_q))) begin
                        terr_d  = 1'b1;
                        state_d = ST_MEASURE;
                        match_d = '0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q        <= ST_SEARCH;
            match_q        <= '0;
            stored_len_q   <= '0;
            stored_lines_q <= '0;
            ref_len_q      <= '0;
            first_q        <= 1'b1;
            cons_q         <= 1'b1;
            terr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            match_q        <= match_d;
            stored_len_q   <= stored_len_d;
            stored_lines_q <= stored_lines_d;
            ref_len_q      <= ref_len_d;
            first_q        <= first_d;
            cons_q         <= cons_d;
            terr_q         <= terr_d;
        end
    end

    assign Locked      = (state_q == ST_LOCKED);
    assign TimingError = terr_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Self-checking bench for vga_timing_decoder: drives a sync generator with
// random idle-cycle noise and compares every cycle with a queue-based model.
module tb_vga_timing_decoder;

    localparam int unsigned MAXV     = 1023;
    localparam int unsigned LOCKF    = 2;
    localparam int          S_SEARCH = 0;
    localparam int          S_MEAS   = 1;
    localparam int          S_LOCK   = 2;

    logic       Clock, Reset, PixelClock, hsync, vsync;
    logic [9:0] xpos, ypos, LineLength, HSyncWidth, FrameLines, VSyncWidth;
    logic       LineEnd, FrameEnd, Locked, TimingError;

    vga_timing_decoder #(.ResolutionSize(10), .LockFrames(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PixelClock  (PixelClock),
        .hsync       (hsync),
        .vsync       (vsync),
        .xpos        (xpos),
        .ypos        (ypos),
        .LineLength  (LineLength),
        .HSyncWidth  (HSyncWidth),
        .FrameLines  (FrameLines),
        .VSyncWidth  (VSyncWidth),
        .LineEnd     (LineEnd),
        .FrameEnd    (FrameEnd),
        .Locked      (Locked),
        .TimingError (TimingError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int unsigned nvec = 0;
    int unsigned miscompares = 0;

    // Reference model state
    bit          m_hprev, m_vprev, m_le, m_fe, m_terr;
    int unsigned m_x, m_y, m_len, m_hw, m_lines, m_vw, m_hlow, m_vlow;
    int unsigned m_match, m_slen, m_slines;
    int          m_state;
    int unsigned frame_q[$];

    // Observations of the DUT for directed checks
    int unsigned fe_cnt, le_since_fe, le_last_frame, terr_cnt, lock_at_fe;
    bit          lock_seen;
    bit          rand_gap = 1'b0;

    function automatic int unsigned sinc(input int unsigned v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    task automatic model_reset();
        m_hprev = 1'b1; m_vprev = 1'b1;
        m_le = 1'b0; m_fe = 1'b0; m_terr = 1'b0;
        m_x = 0; m_y = 0; m_len = 0; m_hw = 0; m_lines = 0; m_vw = 0;
        m_hlow = 0; m_vlow = 0; m_match = 0; m_slen = 0; m_slines = 0;
        m_state = S_SEARCH;
        frame_q.delete();
    endtask

    task automatic model_step(input bit pc, input bit h, input bit v);
        bit hf, hr, vf, vr, hsat, vsat, ok;
        int unsigned nl, nlines;
        m_le = 1'b0; m_fe = 1'b0; m_terr = 1'b0;
        hf = 0; vf = 0; hsat = 0; vsat = 0; ok = 0; nl = 0; nlines = 0;
        if (!pc) return;
        hf = m_hprev && !h;
        hr = !m_hprev && h;
        if (hr) m_hw = m_hlow;
        if (hf) begin
            nl = sinc(m_x); m_len = nl; m_x = 0; m_hlow = 1;
            frame_q.push_back(nl);
        end else begin
            hsat = (m_x == MAXV - 1);
            m_x = sinc(m_x);
            if (!h) m_hlow = sinc(m_hlow);
        end
        m_hprev = h;
        m_le = hf;
        if (hf) begin
            vf = m_vprev && !v;
            vr = !m_vprev && v;
            if (vr) m_vw = m_vlow;
            if (vf) begin
                nlines = sinc(m_y); m_lines = nlines; m_y = 0; m_vlow = 1;
                ok = 1'b1;
                foreach (frame_q[i]) if (frame_q[i] != frame_q[0]) ok = 1'b0;
                frame_q.delete();
            end else begin
                vsat = (m_y == MAXV - 1);
                m_y = sinc(m_y);
                if (!v) m_vlow = sinc(m_vlow);
            end
            m_vprev = v;
            m_fe = vf;
        end
        if (hsat || vsat) begin
            m_terr = 1'b1; m_state = S_SEARCH; m_match = 0;
        end else if (m_state == S_SEARCH) begin
            if (vf) begin m_state = S_MEAS; m_match = 0; end
        end else if (m_state == S_MEAS) begin
            if (vf) begin
                if (ok && nl == m_slen && nlines == m_slines) m_match++;
                else begin m_slen = nl; m_slines = nlines; m_match = ok ? 1 : 0; end
                if (m_match == LOCKF) m_state = S_LOCK;
            end
        end else begin
            if ((hf && nl != m_slen) || (vf && nlines != m_slines)) begin
                m_terr = 1'b1; m_state = S_MEAS; m_match = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".xpos"},        32'(xpos),        m_x);
        chk({tag, ".ypos"},        32'(ypos),        m_y);
        chk({tag, ".LineLength"},  32'(LineLength),  m_len);
        chk({tag, ".HSyncWidth"},  32'(HSyncWidth),  m_hw);
        chk({tag, ".FrameLines"},  32'(FrameLines),  m_lines);
        chk({tag, ".VSyncWidth"},  32'(VSyncWidth),  m_vw);
        chk({tag, ".LineEnd"},     32'(LineEnd),     32'(m_le));
        chk({tag, ".FrameEnd"},    32'(FrameEnd),    32'(m_fe));
        chk({tag, ".Locked"},      32'(Locked),      32'(m_state == S_LOCK));
        chk({tag, ".TimingError"}, 32'(TimingError), 32'(m_terr));
    endtask

    task automatic clear_obs();
        fe_cnt = 0; le_since_fe = 0; le_last_frame = 0; terr_cnt = 0;
        lock_at_fe = 0; lock_seen = 1'b0;
    endtask

    task automatic step(input bit pc, input bit h, input bit v);
        @(negedge Clock);
        PixelClock = pc; hsync = h; vsync = v;
        model_step(pc, h, v);
        @(posedge Clock);
        #1;
        nvec++;
        chk_all("cyc");
        if (FrameEnd) begin le_last_frame = le_since_fe; le_since_fe = 0; fe_cnt++; end
        if (LineEnd) le_since_fe++;
        if (TimingError) terr_cnt++;
        if (Locked && !lock_seen) begin lock_seen = 1'b1; lock_at_fe = fe_cnt; end
    endtask

    task automatic send_line(input int unsigned len, input bit vlow);
        int unsigned g;
        for (int unsigned p = 0; p < len; p++) begin
            step(1'b1, (p < 2) ? 1'b0 : 1'b1, !vlow);
            g = rand_gap ? $urandom_range(3, 0) : 1;
            repeat (g) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_frame(input int bad_idx, input int unsigned bad_len);
        for (int l = 0; l < 10; l++) send_line((l == bad_idx) ? bad_len : 12, l == 0);
    endtask

    task automatic sync_reset();
        @(negedge Clock);
        Reset = 1'b0; PixelClock = 1'b0;
        model_reset();
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        clear_obs();
    endtask

    initial begin
        Reset = 1'b0; PixelClock = 1'b0; hsync = 1'b1; vsync = 1'b1;
        model_reset();
        clear_obs();
        repeat (3) @(posedge Clock);
        #1;
        chk("rst.xpos", 32'(xpos), 0);
        chk("rst.LineLength", 32'(LineLength), 0);
        chk("rst.FrameLines", 32'(FrameLines), 0);
        chk("rst.Locked", 32'(Locked), 0);
        chk("rst.TimingError", 32'(TimingError), 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Lock at default timing
        repeat (4) send_frame(-1, 12);
        chk("lock.at_vfall", lock_at_fe, 3);
        chk("lock.LineLength", 32'(LineLength), 12);
        chk("lock.HSyncWidth", 32'(HSyncWidth), 2);
        chk("lock.FrameLines", 32'(FrameLines), 10);
        chk("lock.VSyncWidth", 32'(VSyncWidth), 1);
        chk("lock.lines_per_frame", le_last_frame, 10);
        chk("lock.xpos_end", 32'(xpos), 11);
        chk("lock.ypos_end", 32'(ypos), 9);

        // Lock loss on a stretched line, then re-lock
        clear_obs();
        send_frame(4, 13);
        chk("loss.terr_pulses", terr_cnt, 1);
        chk("loss.Locked", 32'(Locked), 0);
        send_frame(-1, 12);
        send_frame(-1, 12);
        send_line(12, 1'b1);
        chk("relock.Locked", 32'(Locked), 1);
        for (int l = 1; l < 10; l++) send_line(12, 1'b0);

        // Asynchronous reset mid-frame while locked
        for (int l = 0; l < 5; l++) send_line(12, l == 0);
        @(negedge Clock);
        #2;
        Reset = 1'b0; PixelClock = 1'b0;
        #1;
        model_reset();
        chk("arst.Locked", 32'(Locked), 0);
        chk_all("arst");
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        clear_obs();
        for (int l = 5; l < 10; l++) send_line(12, 1'b0);
        repeat (3) send_frame(-1, 12);
        chk("arst.relock_vfall", lock_at_fe, 3);

        // Horizontal counter saturation
        clear_obs();
        for (int l = 0; l < 3; l++) send_line(12, l == 0);
        send_line(1100, 1'b0);
        chk("sat.xpos", 32'(xpos), 1023);
        chk("sat.terr_pulses", terr_cnt, 1);
        chk("sat.Locked", 32'(Locked), 0);
        for (int l = 4; l < 10; l++) send_line(12, 1'b0);
        repeat (3) send_frame(-1, 12);

        // Inconsistent first measured frame, random enable spacing
        rand_gap = 1'b1;
        sync_reset();
        send_frame(3, 11);
        send_frame(-1, 12);
        send_frame(-1, 12);
        send_line(12, 1'b1);
        chk("incons.lock_vfall", lock_at_fe, 4);
        for (int l = 1; l < 10; l++) send_line(12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_decoder.md
# vga_timing_decoder

Receive-side counterpart to the CRT/VGA timing generator. It samples active-low `hsync`/`vsync` on the pixel-clock enable, measures line length, sync widths and frame height, and recovers sync-referenced `xpos`/`ypos`. It locks once the timing has been stable for `LockFrames` consecutive frames. It sits on the monitor side of the link and also acts as an on-chip checker for the timing generator in self-test builds.

## Interface
- `ResolutionSize`, 10, width of every counter and measurement output.
- `LockFrames`, 2, number of consecutive identical frames required to assert `Locked` (1..7).
- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `PixelClock`  in  1  pixel enable, one `Clock` cycle wide; all sampling happens only when it is high.
- `hsync`  in  1  active-low horizontal sync, synchronous to `Clock`.
- `vsync`  in  1  active-low vertical sync, synchronous to `Clock`.
- `xpos`  out  `ResolutionSize`  pixels since the last hsync falling edge.
- `ypos`  out  `ResolutionSize`  hsync falling edges since the last vsync falling edge.
- `LineLength`  out  `ResolutionSize`  enables between consecutive hsync falls.
- `HSyncWidth`  out  `ResolutionSize`  enables with hsync low, per line.
- `FrameLines`  out  `ResolutionSize`  hsync falls per frame.
- `VSyncWidth`  out  `ResolutionSize`  hsync falls seen while vsync is low.
- `LineEnd`, `FrameEnd`  out  1  one-cycle pulses on a sampled hsync/vsync fall.
- `Locked`  out  1  timing stable.
- `TimingError`  out  1  one-cycle pulse on loss of lock or counter saturation.

## Operation
- Sampling: on `PixelClock`=1, register `hsync`/`vsync` into `hPrev`/`vPrev`. A fall is `prev=1 && input=0`.
- Horizontal:
  - On an hsync fall: `xpos`←0, `LineLength`←`xcount+1`, `LineEnd` pulses.
  - Otherwise `xpos` increments per enable and saturates at all-ones.
  - `HSyncWidth` latches the low-run count at the hsync rise.
- Vertical:
  - On a vsync fall: `ypos`←0, `FrameLines`←lines counted, `FrameEnd` pulses.
  - On each hsync fall: `ypos`+1, saturating.
  - An hsync fall in the same enable as a vsync fall counts toward the new frame, so `ypos`=0 in that case.
  - `VSyncWidth` latches at the vsync rise.
- Per-frame consistency: every `LineLength` within a frame must equal the frame's first line length. Otherwise the frame is marked inconsistent.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH: waits for the first vsync fall, then goes to MEASURE with `match`=0.
  - MEASURE, at each vsync fall:
    - If the frame is consistent and (`LineLength`, `FrameLines`) equal the stored pair: `match`+1.
    - Otherwise store the new pair and set `match`=1 if consistent, 0 if inconsistent.
    - When `match`=`LockFrames`, go to LOCKED and assert `Locked`.
  - LOCKED: any line length or frame-line mismatch pulses `TimingError`, deasserts `Locked`, and goes to MEASURE with `match`=0.
  - Any state: saturation of `xcount` or `ypos` pulses `TimingError` and goes to SEARCH.
- Reset mid-operation: all state clears immediately, and the FSM starts from SEARCH.

## Timing
- Reset values:
  - All counters and measurement outputs are 0.
  - `Locked`, `LineEnd`, `FrameEnd`, `TimingError` are 0.
  - `hPrev`=`vPrev`=1 (idle high).
  - State is SEARCH.
- Latency: an edge sampled at enable k updates its outputs at the same `Clock` edge (one register stage). Pulses are high for exactly that one `Clock` cycle.
- With `PixelClock`=0, outputs hold and no edges are detected, even if the inputs toggle.
- `Locked` rises in the cycle of the vsync fall that completes the `LockFrames`-th matching frame. With the default, that is the 3rd vsync fall after reset.

## Structure
- Shared package `vga_timing_pkg`: state enum (SEARCH/MEASURE/LOCKED), `ResolutionSize` default, saturate-increment function.
- Sub-module `sync_pulse_meter`, instantiated twice:
  - Inputs: tick enable, active-low sync.
  - Outputs: period, low width, position counter, fall pulse, saturation flag.
  - Horizontal instance: tick = `PixelClock`.
  - Vertical instance: tick = `PixelClock` && hsync fall; its position counter feeds `ypos`.
- The top level holds the FSM, the stored pair, `match`, and the consistency flag.

## Test plan
- Lock at default timing: generator with hsync period 12 (low 2), vsync period 10 lines (low 1), `PixelClock` every 2nd cycle.
  - Expect `LineLength`=12, `HSyncWidth`=2, `FrameLines`=10, `VSyncWidth`=1.
  - `Locked` rises at the 3rd vsync fall.
- Position recovery: after lock, `xpos` sequences 0..11 then 0; `ypos` sequences 0..9 then 0. `LineEnd` fires 10 times per `FrameEnd`.
- Lock loss: stretch one line to 13 while locked.
  - `TimingError` pulses once and `Locked` falls in the cycle that line's terminating hsync fall is sampled.
  - Re-lock occurs 2 frames later.
- Inconsistent frame in MEASURE: one line of 11 in frame 2 → `match`=0; `Locked` delays one extra frame.
- Saturation: hold hsync high for 1024 enables → `TimingError` pulses and the FSM goes to SEARCH, with `xpos` held at 1023.
- Async reset mid-frame while locked: `Reset` low for 3 cycles with no `Clock` edge needed.
  - All outputs clear immediately.
  - After release, lock is reacquired at the 3rd vsync fall.
